// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default geometry, NOP encoding
// and the fetch state enumeration.
package fetch_unit_pkg;

    localparam int          PC_W_DEFAULT      = 11;
    localparam int unsigned RESET_VEC_DEFAULT = 0;
    localparam int          PM_DATA_W         = 14;

    localparam logic [7:0] NOP_OPCODE  = 8'h00;
    localparam logic [7:0] NOP_OPERAND = 8'h00;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        SKIP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Program-memory request/response bus between the fetch unit (master) and the
// instruction memory (slave).
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
);
    logic [PC_W-1:0]      pm_addr;
    logic                 pm_req;
    logic [PM_DATA_W-1:0] pm_rdata;
    logic                 pm_valid;

    modport master (output pm_addr, output pm_req, input pm_rdata, input pm_valid);
    modport slave  (input pm_addr, input pm_req, output pm_rdata, output pm_valid);
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: synchronous reset to the reset vector, load has priority over
// increment, and the increment wraps naturally at 2^PC_W.
module pc_reg #(
    parameter int          PC_W      = 11,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_W'(RESET_VEC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests words at pc, captures them into the opcode/operand
// registers, and handles decode stalls, skip bubbles and jump redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          PC_W      = PC_W_DEFAULT,
    parameter int unsigned RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_if.master    pm,
    input  logic            stall,
    input  logic            skip,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    output logic [7:0]      inst_reg,
    output logic [7:0]      operand,
    output logic            inst_valid
);
    fetch_state_e    state_q, state_d;
    logic [7:0]      inst_q, inst_d;
    logic [7:0]      operand_q, operand_d;
    logic            inst_valid_q, inst_valid_d;
    logic            pc_load;
    logic            pc_inc;
    logic            nop_sel;
    logic [PC_W-1:0] pc;

    pc_reg #(
        .PC_W      (PC_W),
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .load_addr (jump_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        operand_d    = operand_q;
        inst_valid_d = inst_valid_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        nop_sel      = 1'b0;

        if (jump_en) begin
            // Redirect wins over everything but reset; any word arriving now is stale.
            pc_load      = 1'b1;
            inst_valid_d = 1'b0;
            state_d      = FETCH;
        end else begin
            case (state_q)
                FETCH, SKIP: begin
                    nop_sel = (state_q == SKIP) || skip;
                    if (pm.pm_valid) begin
                        inst_valid_d = 1'b1;
                        pc_inc       = 1'b1;
                        inst_d       = nop_sel ? NOP_OPCODE  : pm.pm_rdata[13:6];
                        operand_d    = nop_sel ? NOP_OPERAND : pm.pm_rdata[7:0];
                        state_d      = stall ? HOLD : FETCH;
                    end else begin
                        inst_valid_d = 1'b0;
                        state_d      = nop_sel ? SKIP : FETCH;
                    end
                end
                HOLD: begin
                    // The held instruction is consumed on the edge stall drops.
                    if (!stall) begin
                        inst_valid_d = 1'b0;
                        state_d      = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            inst_q       <= NOP_OPCODE;
            operand_q    <= NOP_OPERAND;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            operand_q    <= operand_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign pm.pm_addr = pc;
    assign pm.pm_req  = (state_q != HOLD);
    assign inst_reg   = inst_q;
    assign operand    = operand_q;
    assign inst_valid = inst_valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a behavioural fetch model.
module tb_fetch_unit;
    localparam int PC_W = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            skip;
    logic            jump_en;
    logic [PC_W-1:0] jump_addr;
    logic [7:0]      inst_reg;
    logic [7:0]      operand;
    logic            inst_valid;

    fetch_unit_if #(.PC_W(PC_W)) pm_bus ();

    fetch_unit #(.PC_W(PC_W), .RESET_VEC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .pm         (pm_bus),
        .stall      (stall),
        .skip       (skip),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .inst_reg   (inst_reg),
        .operand    (operand),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    logic [13:0] mem [0:2047];

    // Behavioural model of what decode should observe.
    logic [PC_W-1:0] m_pc;
    logic            m_hold;
    logic            m_skip_pending;
    logic [7:0]      m_inst;
    logic [7:0]      m_op;
    logic            m_valid;

    task automatic tick(input logic r, input logic j, input logic [PC_W-1:0] ja,
                        input logic sk, input logic st, input logic v);
        logic [13:0] word;
        logic        make_nop;
        rst = r; jump_en = j; jump_addr = ja; skip = sk; stall = st;
        pm_bus.pm_valid = v;
        word = mem[m_pc];
        pm_bus.pm_rdata = word;
        @(posedge clk);
        if (r) begin
            m_pc = '0; m_hold = 0; m_skip_pending = 0; m_inst = 0; m_op = 0; m_valid = 0;
        end else if (j) begin
            m_pc = ja; m_valid = 0; m_hold = 0; m_skip_pending = 0;
        end else if (m_hold) begin
            if (!st) begin
                m_hold = 0; m_valid = 0;
            end
        end else begin
            make_nop = m_skip_pending || sk;
            if (v) begin
                m_inst = make_nop ? 8'h00 : word[13:6];
                m_op   = make_nop ? 8'h00 : word[7:0];
                m_valid = 1;
                m_pc = m_pc + 1'b1;
                m_skip_pending = 0;
                m_hold = st;
            end else begin
                m_valid = 0;
                m_skip_pending = make_nop;
            end
        end
        #1;
        txn++;
        $display("txn %0d rst=%b jmp=%b skip=%b stall=%b valid=%b -> addr=%h req=%b inst=%h op=%h iv=%b",
                 txn, r, j, sk, st, v, pm_bus.pm_addr, pm_bus.pm_req, inst_reg, operand, inst_valid);
    endtask

    task automatic test_reset();
        tick(1, 0, '0, 1, 1, 1);
        tick(1, 0, '0, 0, 0, 1);
        checks += 5;
        if (pm_bus.pm_addr !== 11'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", pm_bus.pm_addr); end
        if (pm_bus.pm_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", pm_bus.pm_req); end
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        if (inst_reg !== 8'h00) begin failures++; $display("FAIL reset_inst got=%h exp=00", inst_reg); end
        if (operand !== 8'h00) begin failures++; $display("FAIL reset_operand got=%h exp=00", operand); end
    endtask

    task automatic test_basic();
        tick(0, 0, '0, 0, 0, 1);
        checks += 4;
        if (inst_reg !== 8'h3E) begin failures++; $display("FAIL basic_inst0 got=%h exp=3e", inst_reg); end
        if (operand !== 8'h80) begin failures++; $display("FAIL basic_op0 got=%h exp=80", operand); end
        if (inst_valid !== 1'b1) begin failures++; $display("FAIL basic_valid0 got=%b exp=1", inst_valid); end
        if (pm_bus.pm_addr !== 11'h001) begin failures++; $display("FAIL basic_addr1 got=%h exp=001", pm_bus.pm_addr); end
        tick(0, 0, '0, 0, 0, 1);
        checks += 3;
        if (inst_reg !== 8'hC0) begin failures++; $display("FAIL basic_inst1 got=%h exp=c0", inst_reg); end
        if (operand !== 8'h05) begin failures++; $display("FAIL basic_op1 got=%h exp=05", operand); end
        if (pm_bus.pm_addr !== 11'h002) begin failures++; $display("FAIL basic_addr2 got=%h exp=002", pm_bus.pm_addr); end
    endtask

    task automatic test_stall();
        tick(0, 0, '0, 0, 0, 1);
        tick(0, 0, '0, 0, 1, 1);
        checks += 5;
        if (pm_bus.pm_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", pm_bus.pm_req); end
        if (pm_bus.pm_addr !== 11'h004) begin failures++; $display("FAIL stall_addr got=%h exp=004", pm_bus.pm_addr); end
        if (inst_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", inst_valid); end
        if (inst_reg !== mem[3][13:6]) begin failures++; $display("FAIL stall_inst got=%h exp=%h", inst_reg, mem[3][13:6]); end
        if (operand !== mem[3][7:0]) begin failures++; $display("FAIL stall_op got=%h exp=%h", operand, mem[3][7:0]); end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, '0, 0, 1, 1'($urandom_range(0, 1)));
            checks += 4;
            if (pm_bus.pm_req !== 1'b0) begin failures++; $display("FAIL hold_req[%0d] got=%b exp=0", i, pm_bus.pm_req); end
            if (pm_bus.pm_addr !== 11'h004) begin failures++; $display("FAIL hold_addr[%0d] got=%h exp=004", i, pm_bus.pm_addr); end
            if (inst_valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, inst_valid); end
            if (inst_reg !== mem[3][13:6]) begin failures++; $display("FAIL hold_inst[%0d] got=%h exp=%h", i, inst_reg, mem[3][13:6]); end
        end
        tick(0, 0, '0, 0, 0, 0);
        checks += 3;
        if (pm_bus.pm_req !== 1'b1) begin failures++; $display("FAIL release_req got=%b exp=1", pm_bus.pm_req); end
        if (pm_bus.pm_addr !== 11'h004) begin failures++; $display("FAIL release_addr got=%h exp=004", pm_bus.pm_addr); end
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b exp=0", inst_valid); end
    endtask

    task automatic test_skip();
        tick(0, 0, '0, 0, 0, 1);
        tick(0, 0, '0, 1, 0, 1);
        checks += 4;
        if (inst_reg !== 8'h00) begin failures++; $display("FAIL skip_inst got=%h exp=00", inst_reg); end
        if (operand !== 8'h00) begin failures++; $display("FAIL skip_op got=%h exp=00", operand); end
        if (inst_valid !== 1'b1) begin failures++; $display("FAIL skip_valid got=%b exp=1", inst_valid); end
        if (pm_bus.pm_addr !== 11'h006) begin failures++; $display("FAIL skip_addr got=%h exp=006", pm_bus.pm_addr); end
        tick(0, 0, '0, 0, 0, 1);
        checks += 2;
        if (inst_reg !== mem[6][13:6]) begin failures++; $display("FAIL after_skip_inst got=%h exp=%h", inst_reg, mem[6][13:6]); end
        if (operand !== mem[6][7:0]) begin failures++; $display("FAIL after_skip_op got=%h exp=%h", operand, mem[6][7:0]); end
        tick(0, 0, '0, 1, 0, 0);
        tick(0, 0, '0, 0, 0, 0);
        checks += 2;
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL skip_wait_valid got=%b exp=0", inst_valid); end
        if (pm_bus.pm_addr !== 11'h007) begin failures++; $display("FAIL skip_wait_addr got=%h exp=007", pm_bus.pm_addr); end
        tick(0, 0, '0, 0, 0, 1);
        checks += 3;
        if (inst_reg !== 8'h00) begin failures++; $display("FAIL late_skip_inst got=%h exp=00", inst_reg); end
        if (inst_valid !== 1'b1) begin failures++; $display("FAIL late_skip_valid got=%b exp=1", inst_valid); end
        if (pm_bus.pm_addr !== 11'h008) begin failures++; $display("FAIL late_skip_addr got=%h exp=008", pm_bus.pm_addr); end
    endtask

    task automatic test_jump();
        tick(0, 1, 11'h123, 0, 0, 1);
        checks += 3;
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL jump_valid got=%b exp=0", inst_valid); end
        if (pm_bus.pm_addr !== 11'h123) begin failures++; $display("FAIL jump_addr got=%h exp=123", pm_bus.pm_addr); end
        if (pm_bus.pm_req !== 1'b1) begin failures++; $display("FAIL jump_req got=%b exp=1", pm_bus.pm_req); end
        tick(0, 1, 11'h040, 1, 0, 1);
        tick(0, 0, '0, 0, 0, 1);
        checks += 2;
        if (inst_reg !== 8'h48) begin failures++; $display("FAIL jump_skip_inst got=%h exp=48", inst_reg); end
        if (pm_bus.pm_addr !== 11'h041) begin failures++; $display("FAIL jump_skip_addr got=%h exp=041", pm_bus.pm_addr); end
    endtask

    task automatic test_wrap();
        tick(0, 1, 11'h7FF, 0, 0, 0);
        tick(0, 0, '0, 0, 0, 1);
        checks += 2;
        if (pm_bus.pm_addr !== 11'h000) begin failures++; $display("FAIL wrap_addr got=%h exp=000", pm_bus.pm_addr); end
        if (inst_reg !== mem[11'h7FF][13:6]) begin failures++; $display("FAIL wrap_inst got=%h exp=%h", inst_reg, mem[11'h7FF][13:6]); end
        tick(0, 0, '0, 0, 1, 1);
        tick(1, 0, '0, 1, 1, 1);
        checks += 4;
        if (pm_bus.pm_addr !== 11'h000) begin failures++; $display("FAIL rst_hold_addr got=%h exp=000", pm_bus.pm_addr); end
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_hold_valid got=%b exp=0", inst_valid); end
        if (pm_bus.pm_req !== 1'b1) begin failures++; $display("FAIL rst_hold_req got=%b exp=1", pm_bus.pm_req); end
        if (inst_reg !== 8'h00) begin failures++; $display("FAIL rst_hold_inst got=%h exp=00", inst_reg); end
    endtask

    task automatic test_back_to_back();
        tick(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, '0, 0, 0, 1);
            checks += 3;
            if (inst_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, inst_valid); end
            if (pm_bus.pm_addr !== 11'(i + 1)) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, pm_bus.pm_addr, 11'(i + 1)); end
            if (inst_reg !== mem[i][13:6]) begin failures++; $display("FAIL b2b_inst[%0d] got=%h exp=%h", i, inst_reg, mem[i][13:6]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 15) == 0),
                 11'($urandom_range(0, 2047)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) != 0));
            checks += 5;
            if (pm_bus.pm_addr !== m_pc) begin failures++; $display("FAIL rand_addr[%0d] got=%h exp=%h", i, pm_bus.pm_addr, m_pc); end
            if (pm_bus.pm_req !== !m_hold) begin failures++; $display("FAIL rand_req[%0d] got=%b exp=%b", i, pm_bus.pm_req, !m_hold); end
            if (inst_valid !== m_valid) begin failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, inst_valid, m_valid); end
            if (inst_reg !== m_inst) begin failures++; $display("FAIL rand_inst[%0d] got=%h exp=%h", i, inst_reg, m_inst); end
            if (operand !== m_op) begin failures++; $display("FAIL rand_op[%0d] got=%h exp=%h", i, operand, m_op); end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 14'($urandom);
        mem[0]      = 14'h0F80;
        mem[1]      = 14'h3005;
        mem[5]      = 14'h3FFF;
        mem[7]      = 14'h2AAA;
        mem[11'h40] = 14'h1234;
        m_pc = '0; m_hold = 0; m_skip_pending = 0; m_inst = 0; m_op = 0; m_valid = 0;
        rst = 1; stall = 0; skip = 0; jump_en = 0; jump_addr = '0;
        pm_bus.pm_valid = 0; pm_bus.pm_rdata = '0;

        test_reset();
        test_basic();
        test_stall();
        test_skip();
        test_jump();
        test_wrap();
        test_back_to_back();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
